// File: rtl/lcd_text_controller.sv
// Character-LCD sequencer: waits out power-up, sends the init command set, then
// drains a character FIFO to a 2x16 display with line-break/wrap and clear support.
module lcd_text_controller #(
  parameter int P_CNT_PWRUP = 187_500,
  parameter int P_FIFO_AW   = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr,
  input  logic [7:0] i_char,
  input  logic       i_clear,
  input  logic       i_busy,
  output logic       o_cs,
  output logic       o_RS,
  output logic [7:0] o_data,
  output logic       o_ready,
  output logic       o_full
);
  localparam int DEPTH    = 2 ** P_FIFO_AW;
  localparam int CNT_W    = (P_CNT_PWRUP > 1) ? $clog2(P_CNT_PWRUP) : 1;
  localparam int CNT_LAST_I = P_CNT_PWRUP - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_LAST_I[CNT_W-1:0];
  localparam logic [P_FIFO_AW:0] FULL_CNT = {1'b1, {P_FIFO_AW{1'b0}}};

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO
  } state_t;

  // What the byte currently in flight was, so completion knows what to update.
  typedef enum logic [1:0] {K_INIT, K_CLEAR, K_DATA, K_LINE} kind_t;

  state_t state, state_nxt;
  kind_t  kind, kind_nxt;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       init_idx;
  logic [4:0]       pos;
  logic             clr_pend;
  logic             line_pend;
  logic [7:0]       line_cmd;

  logic             load;
  logic             load_rs;
  logic [7:0]       load_byte;
  logic             pop;
  logic             push;
  logic             done;
  logic             empty;

  logic [7:0]           mem [DEPTH];
  logic [P_FIFO_AW-1:0] wr_ptr;
  logic [P_FIFO_AW-1:0] rd_ptr;
  logic [P_FIFO_AW:0]   count;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  assign o_full = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign push   = i_wr && !o_full;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_PWRUP;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    kind_nxt  = kind;
    load      = 1'b0;
    load_rs   = 1'b0;
    load_byte = 8'h00;
    pop       = 1'b0;
    done      = 1'b0;
    case (state)
      S_PWRUP: if (cnt == CNT_LAST) state_nxt = S_INIT;
      S_INIT: begin
        if (!i_busy) begin
          load      = 1'b1;
          load_byte = init_cmd(init_idx);
          kind_nxt  = K_INIT;
        end
      end
      S_IDLE: begin
        // Pending line address outranks everything so the cursor is never stale.
        if (!i_busy) begin
          if (line_pend) begin
            load      = 1'b1;
            load_byte = line_cmd;
            kind_nxt  = K_LINE;
          end else if (clr_pend) begin
            load      = 1'b1;
            load_byte = CMD_CLEAR;
            kind_nxt  = K_CLEAR;
          end else if (!empty) begin
            load      = 1'b1;
            load_rs   = 1'b1;
            load_byte = mem[rd_ptr];
            kind_nxt  = K_DATA;
            pop       = 1'b1;
          end
        end
      end
      S_ISSUE:   state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (i_busy) state_nxt = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!i_busy) begin
          done      = 1'b1;
          state_nxt = (kind == K_INIT && init_idx != 2'd3) ? S_INIT : S_IDLE;
        end
      end
      default: state_nxt = S_PWRUP;
    endcase
    if (load) state_nxt = S_ISSUE;
  end

  always_comb begin
    o_cs = (state == S_ISSUE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt       <= '0;
      init_idx  <= '0;
      kind      <= K_INIT;
      pos       <= '0;
      clr_pend  <= 1'b0;
      line_pend <= 1'b0;
      line_cmd  <= 8'h00;
      o_ready   <= 1'b0;
      o_RS      <= 1'b0;
      o_data    <= 8'h00;
    end else begin
      if (state == S_PWRUP) cnt <= cnt + CNT_W'(1);
      if (load) begin
        kind   <= kind_nxt;
        o_RS   <= load_rs;
        o_data <= load_byte;
        if (kind_nxt == K_LINE) line_pend <= 1'b0;
      end
      if (done) begin
        case (kind)
          K_INIT: begin
            init_idx <= init_idx + 2'd1;
            if (init_idx == 2'd3) o_ready <= 1'b1;
          end
          K_CLEAR: begin
            pos      <= '0;
            clr_pend <= 1'b0;
          end
          K_DATA: begin
            if (pos == 5'd31) begin
              pos       <= '0;
              line_pend <= 1'b1;
              line_cmd  <= CMD_LINE1;
            end else begin
              pos <= pos + 5'd1;
              if (pos == 5'd15) begin
                line_pend <= 1'b1;
                line_cmd  <= CMD_LINE2;
              end
            end
          end
          default: ;
        endcase
      end
      // A new request arriving while a clear completes must not be lost.
      if (o_ready && i_clear) clr_pend <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + P_FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (P_FIFO_AW+1)'(1);
        2'b01:   count <= count - (P_FIFO_AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_char;
  end

endmodule

// File: tb/tb_lcd_text_controller.sv
// Bench for lcd_text_controller: busy-handshake transmitter model plus a
// reference model of the byte stream a 2x16 text display should receive.
module tb_lcd_text_controller;
  localparam int PWRUP = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] ch;
  logic       clear;
  logic       force_busy;
  logic       rnd_busy;
  logic       busy;
  logic       cs;
  logic       rs;
  logic [7:0] data;
  logic       ready;
  logic       full;

  logic [3:0] bcnt = 4'd0;
  logic       inflight = 1'b0;
  logic       hi_seen = 1'b0;
  logic [8:0] cap = 9'd0;
  int         viol = 0;
  int         checks = 0;
  int         errors = 0;
  int         mpos = 0;
  logic [8:0] got[$];
  logic [8:0] exp[$];

  lcd_text_controller #(.P_CNT_PWRUP(PWRUP), .P_FIFO_AW(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_char(ch), .i_clear(clear),
    .i_busy(busy), .o_cs(cs), .o_RS(rs), .o_data(data), .o_ready(ready),
    .o_full(full)
  );

  always #5 clk = ~clk;

  assign busy = force_busy || (bcnt != 4'd0);

  // Transmitter: busy for a few cycles after each strobe.
  always @(posedge clk) begin
    if (cs) bcnt <= rnd_busy ? 4'($urandom_range(1, 8)) : 4'd5;
    else if (bcnt != 4'd0) bcnt <= bcnt - 4'd1;
  end

  // Record every issued byte; flag strobes during busy and unstable RS/data.
  always @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      hi_seen  <= 1'b0;
    end else if (cs) begin
      if (busy || inflight) viol <= viol + 1;
      got.push_back({rs, data});
      cap      <= {rs, data};
      inflight <= 1'b1;
      hi_seen  <= 1'b0;
    end else if (inflight) begin
      if ({rs, data} !== cap) viol <= viol + 1;
      if (busy) hi_seen <= 1'b1;
      else if (hi_seen) inflight <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_char(input logic [7:0] c);
    exp.push_back({1'b1, c});
    mpos++;
    if (mpos == 16) exp.push_back({1'b0, 8'hC0});
    if (mpos == 32) begin
      mpos = 0;
      exp.push_back({1'b0, 8'h80});
    end
  endtask

  task automatic model_clear();
    exp.push_back({1'b0, 8'h01});
    mpos = 0;
  endtask

  task automatic model_init();
    exp.push_back({1'b0, 8'h38});
    exp.push_back({1'b0, 8'h0C});
    exp.push_back({1'b0, 8'h06});
    exp.push_back({1'b0, 8'h01});
    mpos = 0;
  endtask

  task automatic put_char(input logic [7:0] c, input bit wait_room, input bit do_model);
    int n = 0;
    @(negedge clk);
    while (wait_room && full && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("fifo_room_timeout", 1, 0);
    if (do_model && !full) model_char(c);
    wr = 1'b1;
    ch = c;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic drain_compare(input string tag);
    int n = 0;
    while (got.size() < exp.size() && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (60) @(negedge clk);
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
    check({tag, "_viol"}, viol, 0);
    got.delete();
    exp.delete();
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lowrun;
    logic [7:0] c;
    logic [7:0] held[3];
    string hello;

    rst = 1'b1; wr = 1'b0; ch = 8'h00; clear = 1'b0;
    force_busy = 1'b0; rnd_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", cs, 0);
    check("rst_rs", rs, 0);
    check("rst_data", data, 8'h00);
    check("rst_ready", ready, 0);
    check("rst_full", full, 0);

    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!cs && n < 100);
    check("pwrup_first_cs_cycle", n, PWRUP + 1);
    check("pwrup_first_cs_data", data, 8'h38);

    lowrun = 0;
    n = 0;
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
      if (busy) lowrun = 0;
      else lowrun++;
    end
    check("ready_rises", ready, 1);
    check("ready_one_cycle_after_wait_lo", lowrun, 2);
    check("init_bytes_at_ready", got.size(), 4);
    model_init();
    drain_compare("init");

    // Single character into an empty FIFO: strobe two cycles after the write.
    @(negedge clk);
    wr = 1'b1;
    ch = 8'h48;
    @(negedge clk);
    wr = 1'b0;
    check("lat_n1_cs", cs, 0);
    @(negedge clk);
    check("lat_n2_cs", cs, 1);
    check("lat_n2_data", data, 8'h48);
    check("lat_n2_rs", rs, 1);
    model_char(8'h48);
    hello = "ELLO";
    for (int i = 0; i < hello.len(); i++) put_char(hello[i], 1'b1, 1'b1);
    drain_compare("hello");

    pulse_clear();
    model_clear();
    drain_compare("clear1");

    for (int i = 0; i < 32; i++) begin
      c = 8'($urandom_range(32, 126));
      put_char(c, 1'b1, 1'b1);
    end
    drain_compare("wrap32");

    // Overfill with the transmitter stalled: the 17th write must be dropped.
    @(negedge clk);
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      c = 8'($urandom_range(32, 126));
      put_char(c, 1'b1, 1'b1);
    end
    check("fill_full", full, 1);
    put_char(8'h7E, 1'b0, 1'b1);
    check("fill_full_after_drop", full, 1);
    force_busy = 1'b0;
    drain_compare("fill");

    // Clear requested with characters already queued: clear goes first.
    @(negedge clk);
    force_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      held[i] = 8'($urandom_range(32, 126));
      put_char(held[i], 1'b1, 1'b0);
    end
    pulse_clear();
    model_clear();
    for (int i = 0; i < 3; i++) model_char(held[i]);
    force_busy = 1'b0;
    for (int i = 0; i < 13; i++) begin
      c = 8'($urandom_range(32, 126));
      put_char(c, 1'b1, 1'b1);
    end
    drain_compare("clear_prio");

    rnd_busy = 1'b1;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        c = 8'($urandom_range(0, 255));
        put_char(c, 1'b1, 1'b1);
      end
      drain_compare($sformatf("rnd%0d", r));
      if ($urandom_range(0, 2) == 0) begin
        pulse_clear();
        model_clear();
      end
    end
    drain_compare("rnd_tail");
    rnd_busy = 1'b0;

    // Reset in the middle of a data byte: init repeats, queued chars vanish.
    @(negedge clk);
    force_busy = 1'b1;
    put_char(8'h41, 1'b1, 1'b0);
    put_char(8'h42, 1'b1, 1'b0);
    put_char(8'h43, 1'b1, 1'b0);
    force_busy = 1'b0;
    n = 0;
    while (!cs && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_cs_seen", {cs, rs}, 2'b11);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_cs", cs, 0);
    check("rst_mid_data", data, 8'h00);
    check("rst_mid_ready", ready, 0);
    check("rst_mid_full", full, 0);
    got.delete();
    exp.delete();
    rst = 1'b0;
    n = 0;
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reinit_ready", ready, 1);
    model_init();
    drain_compare("reinit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_text_controller.md
# lcd_text_controller

Upstream command/character sequencer for the 8-bit character LCD path. After reset it waits out LCD power-up, issues the fixed init command set, then drains a 16-entry character FIFO to a 2x16 display. It handles cursor line-break/wrap and screen-clear requests. It drives the LCD byte transmitter through a one-cycle chip-select handshake and uses the transmitter's busy flag as flow control.

## Interface
- P_CNT_PWRUP, 187_500: power-up wait in clock cycles (15 ms at 12.5 MHz).
- P_FIFO_AW, 4: FIFO address width; depth = 2**P_FIFO_AW = 16.

- i_clk  input  1  single clock; all logic on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_wr  input  1  character write strobe, one entry per high cycle
- i_char  input  8  ASCII/CGROM code written with i_wr
- i_clear  input  1  clear-screen request pulse
- i_busy  input  1  transmitter busy flag (high while a byte is in flight)
- o_cs  output  1  one-cycle byte-issue strobe to transmitter
- o_RS  output  1  register select: 0 = command, 1 = data
- o_data  output  8  byte to transmit
- o_ready  output  1  high once init sequence complete
- o_full  output  1  FIFO full (count == 16), combinational from count

## Operation
- Reset (any cycle, including mid-transfer): o_cs=0, o_RS=0, o_data=0x00, o_ready=0, FIFO emptied, cursor r_pos=0, clear-pending=0, counter=0, state S_PWRUP.
- S_PWRUP: count to P_CNT_PWRUP-1, then go to S_INIT with index 0.
- S_INIT: issue commands (RS=0) in order: 0x38 (8-bit, 2-line), 0x0C (display on, cursor off), 0x06 (entry increment), 0x01 (clear). After the 4th completes, set o_ready=1 and go to S_IDLE.
- Issue sub-sequence (shared by all bytes): S_ISSUE -> S_WAIT_HI -> S_WAIT_LO, then return to the dispatcher.
  - S_ISSUE is entered only when i_busy=0. o_cs=1 for that single cycle.
  - S_WAIT_HI holds until i_busy=1.
  - S_WAIT_LO holds until i_busy=0.
  - o_RS/o_data are loaded on entry to S_ISSUE and held constant until S_WAIT_LO exits.
- S_IDLE dispatch, evaluated only when i_busy=0. Priority order:
  1. Clear pending: issue 0x01, then set r_pos=0 and clear the pending flag. FIFO contents are kept.
  2. FIFO non-empty: pop the head, issue it with RS=1, then r_pos += 1.
- Line handling after a data byte completes:
  - If the new r_pos == 16, immediately issue command 0xC0 (line 2).
  - If r_pos was 31, it wraps to 0; immediately issue command 0x80 (line 1).
  - These address commands run before any further dispatch.
- i_clear is latched into the pending flag in any state after o_ready. Pulses during S_PWRUP/S_INIT are ignored; init already clears the screen.
- FIFO write: accepted when i_wr=1 and o_full=0. Writes while full are dropped silently. Read and write in the same cycle are both performed; count is unchanged. Pointers are P_FIFO_AW bits and wrap naturally; count is P_FIFO_AW+1 bits.
- Writes are accepted during init; characters are held until o_ready.

## Timing
- Only one o_cs pulse per byte. Minimum spacing between pulses equals the transmitter round trip plus 2 cycles.
- FIFO latency: i_wr sampled at edge N into an empty FIFO while in S_IDLE with i_busy=0 -> o_cs high in cycle N+2 with o_data = that char and o_RS=1.
- o_ready rises in the cycle after the final init byte's S_WAIT_LO exits.
- i_busy stuck low after o_cs: remain in S_WAIT_HI (no timeout). Reset is the only escape.
- Power-up: first o_cs (0x38) asserts P_CNT_PWRUP+1 cycles after reset deasserts.

## Test plan
- Reset release, P_CNT_PWRUP=10, transmitter model with 5-cycle busy -> bytes 0x38,0x0C,0x06,0x01 all RS=0, first o_cs at cycle 11; o_ready=1 after the 4th completes.
- Write "HELLO" after o_ready -> five RS=1 transfers 0x48,0x45,0x4C,0x4C,0x4F in order, each with one o_cs pulse and o_data held until busy falls.
- Write 17 chars -> 16 data bytes, then command 0xC0, then the 17th char. After 32 chars total, command 0x80 follows the 32nd.
- Fill FIFO with 16 writes while busy is held high, plus 1 more write -> o_full=1, 17th char dropped; exactly 16 data bytes are emitted afterward.
- Assert i_clear with 3 chars queued -> 0x01 (RS=0) is issued first, then the 3 chars; the first char lands at r_pos 0.
- Assert i_reset during S_WAIT_LO of a data byte -> next cycle o_cs=0, o_data=0x00, o_ready=0, o_full=0. The full init sequence repeats and previously queued chars are never sent.
